// File: rtl/card_shoe.sv
// Multi-deck card source: fills a register array with card indices, shuffles it in place
// (Fisher-Yates, LFSR-driven) and serves one card per accepted draw, delivered a cycle later.
module card_shoe #(
   parameter int unsigned NUM_DECKS = 1,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int unsigned LOW_MARK  = 15
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_shuffle,
   input  logic       i_draw_req,
   output logic       o_draw_ready,
   output logic       o_card_valid,
   output logic [3:0] o_card_rank,
   output logic [1:0] o_card_suit,
   output logic [7:0] o_cards_left,
   output logic       o_shuffling,
   output logic       o_low
);
   localparam int unsigned N       = 52 * NUM_DECKS;
   localparam int unsigned AW      = $clog2(N);
   localparam logic [7:0]  N_CARDS = 8'(N);
   localparam logic [7:0]  LAST    = 8'(N - 1);

   localparam logic [2:0] S_FILL    = 3'd0;
   localparam logic [2:0] S_PICK    = 3'd1;
   localparam logic [2:0] S_SWAP    = 3'd2;
   localparam logic [2:0] S_READY   = 3'd3;
   localparam logic [2:0] S_DELIVER = 3'd4;

   logic [2:0]    state;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_next;
   logic [7:0]    idx;
   logic [7:0]    top;
   logic [7:0]    mask;
   logic [7:0]    rnd;
   logic [AW-1:0] pick;
   logic [5:0]    fill_card;
   logic [5:0]    top_card;
   logic [5:0]    dec_off;
   logic [3:0]    dec_rank;
   logic [1:0]    dec_suit;
   logic [5:0]    mem [N];
   logic          draw_ready;
   logic          accept;
   logic          shuffling;
   logic          card_valid;
   logic [3:0]    card_rank;
   logic [1:0]    card_suit;

   always_comb begin
      lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
      // Smear the index downward to get the smallest all-ones mask covering it.
      mask = idx | (idx >> 1) | (idx >> 2) | (idx >> 3) | (idx >> 4) | (idx >> 5) |
             (idx >> 6) | (idx >> 7);
      rnd = lfsr[7:0] & mask;
      shuffling  = (state == S_FILL) || (state == S_PICK) || (state == S_SWAP);
      draw_ready = (state == S_READY) && (top < N_CARDS);
      accept     = draw_ready && i_draw_req && !i_shuffle;
   end

   always_comb begin
      top_card = mem[top[AW-1:0]];
      if (top_card >= 6'd39) begin
         dec_suit = 2'd3;
         dec_off  = 6'd39;
      end else if (top_card >= 6'd26) begin
         dec_suit = 2'd2;
         dec_off  = 6'd26;
      end else if (top_card >= 6'd13) begin
         dec_suit = 2'd1;
         dec_off  = 6'd13;
      end else begin
         dec_suit = 2'd0;
         dec_off  = 6'd0;
      end
      dec_rank = 4'(top_card - dec_off) + 4'd1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= S_FILL;
         lfsr       <= SEED;
         idx        <= '0;
         top        <= '0;
         pick       <= '0;
         fill_card  <= '0;
         card_valid <= 1'b0;
         card_rank  <= '0;
         card_suit  <= '0;
      end else begin
         lfsr       <= lfsr_next;
         card_valid <= accept;
         case (state)
            S_FILL: begin
               fill_card <= (fill_card == 6'd51) ? 6'd0 : fill_card + 6'd1;
               if (idx == LAST) begin
                  state <= S_PICK;
               end else begin
                  idx <= idx + 8'd1;
               end
            end
            S_PICK: begin
               // Out-of-range draws are rejected and retried to keep the shuffle unbiased.
               if (rnd <= idx) begin
                  pick  <= rnd[AW-1:0];
                  state <= S_SWAP;
               end
            end
            S_SWAP: begin
               if (idx == 8'd1) begin
                  top   <= '0;
                  state <= S_READY;
               end else begin
                  idx   <= idx - 8'd1;
                  state <= S_PICK;
               end
            end
            S_READY: begin
               if (i_shuffle) begin
                  idx       <= '0;
                  fill_card <= '0;
                  top       <= '0;
                  state     <= S_FILL;
               end else if (accept) begin
                  card_rank <= dec_rank;
                  card_suit <= dec_suit;
                  top       <= top + 8'd1;
                  state     <= S_DELIVER;
               end
            end
            S_DELIVER: begin
               if (top == N_CARDS) begin
                  idx       <= '0;
                  fill_card <= '0;
                  top       <= '0;
                  state     <= S_FILL;
               end else begin
                  state <= S_READY;
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

   // Card storage needs no reset: every shuffle rewrites all entries first.
   always_ff @(posedge i_clk) begin
      if (state == S_FILL) begin
         mem[idx[AW-1:0]] <= fill_card;
      end else if (state == S_SWAP) begin
         mem[idx[AW-1:0]] <= mem[pick];
         mem[pick]        <= mem[idx[AW-1:0]];
      end
   end

   assign o_draw_ready = draw_ready;
   assign o_card_valid = card_valid;
   assign o_card_rank  = card_rank;
   assign o_card_suit  = card_suit;
   assign o_shuffling  = shuffling;
   assign o_cards_left = shuffling ? N_CARDS : (N_CARDS - top);
   assign o_low        = (o_cards_left < 8'(LOW_MARK));

endmodule

// File: tb/tb_card_shoe.sv
// Randomized scoreboard bench for card_shoe: three shoes (1 deck/ACE1, 1 deck/1234, 2 decks/ACE1)
// checked against a Fisher-Yates reference model that predicts deal order and shuffle length.
module tb_card_shoe;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [2:0] shuf;
   wire  [2:0] ready;
   wire  [2:0] valid;
   wire  [2:0] shuffling;
   wire  [2:0] low;
   wire  [2:0][3:0] rank;
   wire  [2:0][1:0] suit;
   wire  [2:0][7:0] left;

   always #5 clk = ~clk;

   card_shoe #(.NUM_DECKS(1), .SEED(16'hACE1), .LOW_MARK(15)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_shuffle(shuf[0]), .i_draw_req(req[0]),
      .o_draw_ready(ready[0]), .o_card_valid(valid[0]), .o_card_rank(rank[0]),
      .o_card_suit(suit[0]), .o_cards_left(left[0]), .o_shuffling(shuffling[0]),
      .o_low(low[0]));
   card_shoe #(.NUM_DECKS(1), .SEED(16'h1234), .LOW_MARK(15)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_shuffle(shuf[1]), .i_draw_req(req[1]),
      .o_draw_ready(ready[1]), .o_card_valid(valid[1]), .o_card_rank(rank[1]),
      .o_card_suit(suit[1]), .o_cards_left(left[1]), .o_shuffling(shuffling[1]),
      .o_low(low[1]));
   card_shoe #(.NUM_DECKS(2), .SEED(16'hACE1), .LOW_MARK(15)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_shuffle(shuf[2]), .i_draw_req(req[2]),
      .o_draw_ready(ready[2]), .o_card_valid(valid[2]), .o_card_rank(rank[2]),
      .o_card_suit(suit[2]), .o_cards_left(left[2]), .o_shuffling(shuffling[2]),
      .o_low(low[2]));

   typedef struct {
      int k;
      int card;
      int left;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [15:0] lfsr_m [3];
   int          deck [3][208];
   int          top_m [3];
   int          fill_base [3];
   int          shuf_len [3];
   bit          awaiting [3];
   int          last_valid [3];
   int          tally [3][52];
   int          log_c [3][256];
   int          log_n [3];
   int          ref_deal [10];

   function automatic int nof(input int k);
      return (k == 2) ? 104 : 52;
   endfunction

   function automatic logic [15:0] seedof(input int k);
      return (k == 1) ? 16'h1234 : 16'hACE1;
   endfunction

   function automatic logic [15:0] step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference shuffle: fill, then Fisher-Yates from the top with rejection sampling,
   // one LFSR step per cycle; yields the deck order and cycles until draws are served.
   task automatic model_shuffle(input int k, input logic [15:0] l0);
      logic [15:0] l;
      int n, i, r, m, cycles, t;
      n = nof(k);
      l = l0;
      for (int c = 0; c < n; c++) begin
         deck[k][c] = c % 52;
         l = step(l);
      end
      cycles = n;
      i = n - 1;
      while (i >= 1) begin
         m = 1;
         while (m < i) m = m * 2 + 1;
         r = int'(l[7:0]) & m;
         l = step(l);
         cycles++;
         if (r <= i) begin
            t = deck[k][i];
            deck[k][i] = deck[k][r];
            deck[k][r] = t;
            l = step(l);
            cycles++;
            i--;
         end
      end
      shuf_len[k] = cycles;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) lfsr_m[k] <= rst ? seedof(k) : step(lfsr_m[k]);
   end

   // Monitor: pops the scoreboard whenever a shoe presents a card.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (valid[k]) begin
               if (sb.size() == 0 || sb[0].k != k) begin
                  check("unexpected_valid", int'(valid[k]), 0);
               end else begin
                  e = sb.pop_front();
                  check("rank", int'(rank[k]), e.card % 13 + 1);
                  check("suit", int'(suit[k]), e.card / 13);
                  check("cards_left", int'(left[k]), e.left);
                  check("low", int'(low[k]), (e.left < 15) ? 1 : 0);
                  check("valid_spacing", (cyc - last_valid[k] >= 2) ? 1 : 0, 1);
                  last_valid[k] = cyc;
                  if (log_n[k] < nof(k)) tally[k][int'(suit[k]) * 13 + int'(rank[k]) - 1]++;
                  if (log_n[k] < 256) begin
                     log_c[k][log_n[k]] = int'(suit[k]) * 13 + int'(rank[k]) - 1;
                     log_n[k]++;
                  end
               end
            end
         end
      end
   end

   // Shuffle watcher: outputs at shuffle start and exact cycle draws become available.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (awaiting[k] && cyc >= fill_base[k]) begin
               if (cyc == fill_base[k]) begin
                  check("shuffling_at_start", int'(shuffling[k]), 1);
                  check("left_at_start", int'(left[k]), nof(k));
               end
               if (ready[k]) begin
                  check("ready_latency", cyc - fill_base[k], shuf_len[k]);
                  awaiting[k] = 1'b0;
               end else if (cyc > fill_base[k] + shuf_len[k] + 10) begin
                  check("ready_timeout", int'(ready[k]), 1);
                  awaiting[k] = 1'b0;
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      shuf = '0;
      sb.delete();
      for (int k = 0; k < 3; k++) begin
         awaiting[k] = 1'b0;
         log_n[k] = 0;
         for (int c = 0; c < 52; c++) tally[k][c] = 0;
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_valid", int'(valid[k]), 0);
         check("rst_rank", int'(rank[k]), 0);
         check("rst_suit", int'(suit[k]), 0);
         check("rst_ready", int'(ready[k]), 0);
         check("rst_shuffling", int'(shuffling[k]), 1);
         check("rst_left", int'(left[k]), nof(k));
         check("rst_low", int'(low[k]), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         top_m[k] = 0;
         fill_base[k] = cyc;
         model_shuffle(k, seedof(k));
         awaiting[k] = 1'b1;
      end
   endtask

   // Called at a negedge where the DUT will accept on the coming edge.
   task automatic accept_k(input int k);
      exp_t e;
      e.k = k;
      e.card = deck[k][top_m[k]];
      e.left = nof(k) - top_m[k] - 1;
      sb.push_back(e);
      top_m[k]++;
      if (top_m[k] == nof(k)) begin
         top_m[k] = 0;
         fill_base[k] = cyc + 2;
         model_shuffle(k, step(step(lfsr_m[k])));
         awaiting[k] = 1'b1;
      end
   endtask

   task automatic draw(input int k, input int count, input bit rnd_gap);
      int done = 0;
      int gap = 0;
      int budget = 0;
      while (done < count) begin
         @(negedge clk);
         budget++;
         if (budget > 5000) begin
            check("draw_timeout", done, count);
            break;
         end
         if (gap > 0) begin
            req[k] = 1'b0;
            gap--;
         end else begin
            req[k] = 1'b1;
            if (ready[k]) begin
               accept_k(k);
               done++;
               gap = rnd_gap ? int'($urandom_range(0, 3)) : 0;
            end
         end
      end
      @(negedge clk);
      req[k] = 1'b0;
      @(negedge clk);
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic wait_ready(input int k);
      int budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!ready[k] && budget < 2000);
      check("ready_seen", int'(ready[k]), 1);
   endtask

   task automatic check_tally(input int k, input int want);
      int bad = 0;
      for (int c = 0; c < 52; c++) if (tally[k][c] != want) bad++;
      check("tally_cells_off", bad, 0);
   endtask

   task automatic compare_ref();
      for (int i = 0; i < 10; i++) check("repeat_deal", log_c[0][i], ref_deal[i]);
   endtask

   initial begin
      int same;
      rst  = 1'b0;
      req  = '0;
      shuf = '0;
      for (int k = 0; k < 3; k++) last_valid[k] = -100;
      #2;
      do_reset();

      // Full deck with request held, including one card after the automatic reshuffle.
      draw(0, 53, 1'b0);
      check_tally(0, 1);
      for (int i = 0; i < 10; i++) ref_deal[i] = log_c[0][i];

      // Shuffle and draw in the same cycle: shuffle wins, no card.
      draw(0, int'($urandom_range(3, 20)), 1'b1);
      wait_ready(0);
      shuf[0] = 1'b1;
      req[0]  = 1'b1;
      top_m[0] = 0;
      fill_base[0] = cyc + 1;
      model_shuffle(0, step(lfsr_m[0]));
      awaiting[0] = 1'b1;
      @(negedge clk);
      shuf[0] = 1'b0;
      check("no_valid_on_shuffle", int'(valid[0]), 0);
      check("shuffling_after_cmd", int'(shuffling[0]), 1);
      check("left_after_cmd", int'(left[0]), 52);
      draw(0, 5, 1'b1);

      // Determinism and seed sensitivity.
      do_reset();
      draw(0, 10, 1'b1);
      draw(1, 10, 1'b1);
      compare_ref();
      same = 0;
      for (int i = 0; i < 10; i++) if (log_c[0][i] == log_c[1][i]) same++;
      check("seed_changes_order", (same == 10) ? 1 : 0, 0);

      // Reset in the middle of the pick/swap phase.
      do_reset();
      repeat (nof(0) + 5 + int'($urandom_range(0, 20))) @(negedge clk);
      check("in_shuffle_before_rst", int'(shuffling[0]), 1);
      @(posedge clk);
      #1;
      do_reset();
      draw(0, 10, 1'b1);
      compare_ref();

      // Reset one cycle after an accept: the pending card must never appear.
      do_reset();
      wait_ready(0);
      req[0] = 1'b1;
      accept_k(0);
      @(posedge clk);
      #1;
      do_reset();
      draw(0, 10, 1'b1);
      compare_ref();

      // Two decks: every card exactly twice, low flag across the threshold.
      do_reset();
      draw(2, 104, 1'b1);
      check_tally(2, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
